// File: rtl/shifter2_pkg.sv
// Shared types and the fixed logical left-shift helper for the shift-left-by-2 unit.
// Used by the combinational core and by the testbench reference model.
package shifter2_pkg;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 2;

    typedef logic [DATA_W-1:0] word_t;

    // Logical left shift with zero fill; bits shifted past the MSB are discarded.
    function automatic word_t sll_fixed(input word_t value, input int amount);
        return value << amount;
    endfunction

endpackage

// File: rtl/shifter2_core.sv
// Combinational core of the shift-left-by-2 unit: produces the shifted word and,
// when SHIFTER2_OVF_EN is defined, the OR of the bits pushed out of the top.
module shifter2_core
    import shifter2_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHAMT = SHIFT_W
) (
    input  logic [WIDTH-1:0] in,
`ifdef SHIFTER2_OVF_EN
    output logic             lost,
`endif
    output logic [WIDTH-1:0] shifted
);

    // The package helper is sized to word_t, so it only serves the default width;
    // other widths use the equivalent explicit concatenation.
    if (WIDTH == DATA_W) begin : g_pkg_shift
        assign shifted = sll_fixed(in, SHAMT);
    end else begin : g_slice_shift
        assign shifted = {in[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
    end

`ifdef SHIFTER2_OVF_EN
    // Any set bit among the discarded MSBs means the byte offset no longer fits.
    assign lost = |in[WIDTH-1 -: SHAMT];
`endif

endmodule

// File: rtl/shifter2_sll2.sv
// Registered logical shift-left-by-2 unit (word offset -> byte offset) for the
// MIPS branch/jump target path. Valid-qualified, one-cycle latency, no stall.
// Optional overflow flag output 'ovf' is built only when SHIFTER2_OVF_EN is defined.
module shifter2_sll2
    import shifter2_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SHAMT = SHIFT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
`ifdef SHIFTER2_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] shifted;
`ifdef SHIFTER2_OVF_EN
    logic             lost;
`endif

    shifter2_core #(
        .WIDTH (WIDTH),
        .SHAMT (SHAMT)
    ) u_core (
        .in      (in),
`ifdef SHIFTER2_OVF_EN
        .lost    (lost),
`endif
        .shifted (shifted)
    );

    // Output registers: valid follows in_valid every cycle, data loads only on valid.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled synchronously here; data only holds when in_valid=0,
        // so stale inputs never reach out and nothing unknown is loaded.
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register updating from
            // pre-edge values, independent of statement order.
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= shifted;
            end
        end
    end

`ifdef SHIFTER2_OVF_EN
    // Overflow flag registered alongside out under the same load rule.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= lost;
        end
    end
`endif

endmodule

// File: tb/tb_shifter2_sll2.sv
// Self-checking bench for shifter2_sll2 (WIDTH=32, SHAMT=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that loaded them.
module tb_shifter2_sll2;
    import shifter2_pkg::*;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] din;
    logic        out_valid;
    logic [31:0] dout;
`ifdef SHIFTER2_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    shifter2_sll2 #(
        .WIDTH (32),
        .SHAMT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .out_valid (out_valid),
        .out       (dout)
`ifdef SHIFTER2_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full clock: the rising edge loads, then we land on the falling edge to sample.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        vecs[8];
    logic [31:0] words[8];

    initial begin
        vecs[0] = '{32'h0000_0002, 32'h0000_0008, 1'b0};
        vecs[1] = '{32'h0000_0010, 32'h0000_0040, 1'b0};
        vecs[2] = '{32'h0000_FFFF, 32'h0003_FFFC, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h0000_F0F0, 32'h0003_C3C0, 1'b0};
        vecs[5] = '{32'h0000_1234, 32'h0000_48D0, 1'b0};
        vecs[6] = '{32'hC000_0001, 32'h0000_0004, 1'b1};
        vecs[7] = '{32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        din      = 32'h0000_FFFF;
        @(negedge clk);

        // 1: reset dominates in_valid for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_out", dout, 32'h0);
            check("reset_valid", {31'b0, out_valid}, 32'h0);
`ifdef SHIFTER2_OVF_EN
            check("reset_ovf", {31'b0, ovf}, 32'h0);
`endif
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("idle_after_reset_valid", {31'b0, out_valid}, 32'h0);

        // 2 and 3: directed table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            din      = vecs[i].din;
            tick();
            check($sformatf("vec%0d_out", i), dout, vecs[i].exp_out);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
`ifdef SHIFTER2_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
`endif
        end

        // 4: result then three idle cycles with garbage on in; out and ovf hold
`ifdef SHIFTER2_OVF_EN
        in_valid = 1'b1;
        din      = 32'h4000_1234;
        tick();
        check("ovf_set_before_hold", {31'b0, ovf}, 32'h1);
        check("ovf_set_out", dout, 32'h0000_48D0);
`endif
        in_valid = 1'b1;
        din      = 32'h0000_1234;
        tick();
        check("hold_first_valid", {31'b0, out_valid}, 32'h1);
        check("hold_first_out", dout, 32'h0000_48D0);
        in_valid = 1'b0;
        din      = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_valid", i), {31'b0, out_valid}, 32'h0);
            check($sformatf("hold%0d_out", i), dout, 32'h0000_48D0);
`ifdef SHIFTER2_OVF_EN
            check($sformatf("hold%0d_ovf", i), {31'b0, ovf}, 32'h0);
`endif
        end

        // 5: back-to-back random stream, one result per cycle
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom;
        end
        in_valid = 1'b1;
        din      = words[0];
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("stream%0d_valid", i - 1), {31'b0, out_valid}, 32'h1);
            check($sformatf("stream%0d_out", i - 1), dout, sll_fixed(words[i-1], 2));
`ifdef SHIFTER2_OVF_EN
            check($sformatf("stream%0d_ovf", i - 1), {31'b0, ovf}, {31'b0, |words[i-1][31:30]});
`endif
            if (i < 8) begin
                din = words[i];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("stream_end_valid", {31'b0, out_valid}, 32'h0);

        // 6: reset at the same edge as a valid input drops the result
        in_valid = 1'b1;
        din      = 32'hC000_1234;
        rst_n    = 1'b0;
        tick();
        check("midreset_out", dout, 32'h0);
        check("midreset_valid", {31'b0, out_valid}, 32'h0);
`ifdef SHIFTER2_OVF_EN
        check("midreset_ovf", {31'b0, ovf}, 32'h0);
`endif
        rst_n = 1'b1;
        din   = 32'h0000_0010;
        tick();
        check("resume_out", dout, 32'h0000_0040);
        check("resume_valid", {31'b0, out_valid}, 32'h1);
        in_valid = 1'b0;
        tick();
        check("resume_idle_valid", {31'b0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
